ws2812b_frame_sequencer: RTL and testbench

Upstream companion to the `ws2812b` bit encoder. It holds one frame of pixel colours for a strip of `NUM_LEDS` devices. On `start` it presents the pixels one at a time on `r`/`g`/`b` with `enable`, paces each transfer on the encoder's `bit_ready` handshake, and then holds the line idle for the latch/reset gap. A host writes pixels through a simple synchronous write port.

---
 rtl/ws2812b_pkg.sv | 30 +++
 rtl/ws2812b_pixel_ram.sv | 29 ++
 rtl/ws2812b_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_ws2812b_frame_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// Shared constants for the WS2812B frame sequencer: pixel width, 50 MHz
// timing defaults, one-hot FSM encoding and the shared counter sizing helper.
package ws2812b_pkg;

   localparam int WS2812B_PIXEL_W = 24;

   // 280 us latch gap and a generous per-edge handshake limit at 50 MHz
   localparam int WS2812B_LATCH_CYCLES_DEF   = 14000;
   localparam int WS2812B_TIMEOUT_CYCLES_DEF = 4096;

   typedef logic [WS2812B_PIXEL_W-1:0] ws2812b_pixel_t;

   localparam logic [6:0] ST_IDLE    = 7'b000_0001;
   localparam logic [6:0] ST_LOAD    = 7'b000_0010;
   localparam logic [6:0] ST_ASSERT  = 7'b000_0100;
   localparam logic [6:0] ST_WAIT_HI = 7'b000_1000;
   localparam logic [6:0] ST_WAIT_LO = 7'b001_0000;
   localparam logic [6:0] ST_NEXT    = 7'b010_0000;
   localparam logic [6:0] ST_LATCH   = 7'b100_0000;

   // Width of the counter shared by the latch gap and the handshake timeout.
   // It only ever holds values up to max(latch, timeout) - 1.
   function automatic int ws2812b_cnt_w(input int latch_cycles, input int timeout_cycles);
      int m;
      m = (latch_cycles > timeout_cycles) ? latch_cycles : timeout_cycles;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/ws2812b_pixel_ram.sv
// Frame buffer: one synchronous write port, one registered read port with a
// single cycle of read latency. No reset so it maps onto block/distributed RAM.
// Entries at or above the frame length are never written by the sequencer.
module ws2812b_pixel_ram
   import ws2812b_pkg::*;
#(
   parameter int ADDR_W = 3
) (
   input  logic                clock,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  ws2812b_pixel_t      wdata,
   input  logic [ADDR_W-1:0]   raddr,
   output ws2812b_pixel_t      rdata
);

   ws2812b_pixel_t mem [2**ADDR_W];

   // host write port
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // registered read for the sequencer
   always_ff @(posedge clock) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Walks a frame of pixels out to the ws2812b bit encoder, one word per
// bit_ready handshake, then holds the line idle for the latch gap.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start; host may write pixels
// LOAD     | pixel RAM read of pix_idx in flight
// ASSERT   | present pixel on r/g/b, raise enable, clear timeout counter
// WAIT_HI  | waiting for encoder to accept the word (bit_ready high)
// WAIT_LO  | waiting for encoder to finish the word (bit_ready low)
// NEXT     | advance to next pixel or start the latch gap
// LATCH    | line idle while the counter runs down; done pulses at zero
module ws2812b_frame_sequencer
   import ws2812b_pkg::*;
#(
   parameter int NUM_LEDS       = 8,
   parameter int ADDR_W         = 3,
   parameter int LATCH_CYCLES   = WS2812B_LATCH_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = WS2812B_TIMEOUT_CYCLES_DEF
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [WS2812B_PIXEL_W-1:0]  wr_data,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic                        enable,
   output logic [7:0]                  r,
   output logic [7:0]                  g,
   output logic [7:0]                  b,
   input  logic                        bit_ready
);

   localparam int CNT_W = ws2812b_cnt_w(LATCH_CYCLES, TIMEOUT_CYCLES);

   localparam logic [ADDR_W:0]   NUM_LEDS_EXT = (ADDR_W+1)'(NUM_LEDS);
   localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_LEDS - 1);
   localparam logic [CNT_W-1:0]  LATCH_LOAD   = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TO_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [6:0]        state;
   logic [ADDR_W-1:0] pix_idx;
   logic [CNT_W-1:0]  cnt;
   logic              ram_we;
   ws2812b_pixel_t    rd_data;

   // Host writes only land while idle and inside the frame
   assign ram_we = wr_en && !busy && ({1'b0, wr_addr} < NUM_LEDS_EXT);

   ws2812b_pixel_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock (clock),
      .we    (ram_we),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (pix_idx),
      .rdata (rd_data)
   );

   // Frame sequencing FSM; cnt is the timeout up-counter in WAIT_* and the
   // latch down-counter in LATCH
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         pix_idx <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         error   <= 1'b0;
         enable  <= 1'b0;
         r       <= '0;
         g       <= '0;
         b       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_LOAD;
                  busy    <= 1'b1;
                  pix_idx <= '0;
                  error   <= 1'b0;
               end
            end
            ST_LOAD: begin
               state <= ST_ASSERT;
            end
            ST_ASSERT: begin
               {r, g, b} <= rd_data;
               enable    <= 1'b1;
               cnt       <= '0;
               state     <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (bit_ready) begin
                  cnt   <= '0;
                  state <= ST_WAIT_LO;
               end else if (cnt == TO_LAST) begin
                  error  <= 1'b1;
                  enable <= 1'b0;
                  cnt    <= LATCH_LOAD;
                  state  <= ST_LATCH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_WAIT_LO: begin
               if (!bit_ready) begin
                  enable <= 1'b0;
                  state  <= ST_NEXT;
               end else if (cnt == TO_LAST) begin
                  error  <= 1'b1;
                  enable <= 1'b0;
                  cnt    <= LATCH_LOAD;
                  state  <= ST_LATCH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_NEXT: begin
               if (pix_idx == LAST_IDX) begin
                  cnt   <= LATCH_LOAD;
                  state <= ST_LATCH;
               end else begin
                  pix_idx <= pix_idx + 1'b1;
                  state   <= ST_LOAD;
               end
            end
            ST_LATCH: begin
               enable <= 1'b0;
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy   <= 1'b0;
               enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Bench for ws2812b_frame_sequencer: a behavioural encoder responder, a pixel
// scoreboard checked at every enable rise, table-driven frames and a few
// hand-written corner sequences (busy writes, reset, handshake timeout).
module tb_ws2812b_frame_sequencer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;

   logic        wr_en, start, bit_ready;
   logic [2:0]  wr_addr;
   logic [23:0] wr_data;
   logic        busy, done, error, enable;
   logic [7:0]  r, g, b;

   logic        t_wr_en, t_start, t_bit_ready;
   logic [2:0]  t_wr_addr;
   logic [23:0] t_wr_data;
   logic        t_busy, t_done, t_error, t_enable;
   logic [7:0]  t_r, t_g, t_b;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          start_cyc, last_fall, en_pulses;
   logic        en_m, en_r, arm;
   int          hold;
   logic [23:0] cur_px;
   logic [23:0] q[$];

   typedef struct {
      logic [2:0][2:0]  addr;
      logic [2:0][23:0] data;
      logic [2:0][23:0] exp;
   } vec_t;
   vec_t vecs[3];

   ws2812b_frame_sequencer #(
      .NUM_LEDS(3), .ADDR_W(3), .LATCH_CYCLES(100), .TIMEOUT_CYCLES(4096)
   ) dut (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .busy(busy), .done(done),
      .error(error), .enable(enable), .r(r), .g(g), .b(b),
      .bit_ready(bit_ready)
   );

   ws2812b_frame_sequencer #(
      .NUM_LEDS(3), .ADDR_W(3), .LATCH_CYCLES(100), .TIMEOUT_CYCLES(64)
   ) dut_to (
      .clock(clock), .reset_n(reset_n), .wr_en(t_wr_en), .wr_addr(t_wr_addr),
      .wr_data(t_wr_data), .start(t_start), .busy(t_busy), .done(t_done),
      .error(t_error), .enable(t_enable), .r(t_r), .g(t_g), .b(t_b),
      .bit_ready(t_bit_ready)
   );

   always #10 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // Encoder model: bit_ready rises 2 cycles after enable, held 1440 cycles
   initial begin
      bit_ready = 1'b0; arm = 1'b0; hold = 0; en_r = 1'b0;
      forever begin
         @(posedge clock);
         if (!reset_n) begin
            bit_ready <= 1'b0; arm <= 1'b0; hold <= 0; en_r <= 1'b0;
         end else begin
            if (arm) begin
               arm <= 1'b0; bit_ready <= 1'b1; hold <= 1439;
            end else if (bit_ready) begin
               if (hold == 0) bit_ready <= 1'b0;
               else hold <= hold - 1;
            end
            if (enable && !en_r) arm <= 1'b1;
            en_r <= enable;
         end
      end
   end

   // Pixel monitor: scoreboard pop on enable rise, pacing and stability checks
   initial begin
      en_m = 1'b0; cur_px = '0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            en_m = 1'b0;
         end else begin
            if (enable && !en_m) begin
               if (en_pulses == 0) check("first_enable_latency", cyc - start_cyc, 2);
               else check("enable_gap", cyc - last_fall, 3);
               en_pulses++;
               cur_px = {r, g, b};
               if (q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL pixel_rgb: got %0h expected none queued", cur_px);
               end else begin
                  check("pixel_rgb", cur_px, q.pop_front());
               end
            end
            if (!enable && en_m) begin
               check("rgb_stable", {r, g, b}, cur_px);
               last_fall = cyc;
            end
            en_m = enable;
         end
      end
   end

   task automatic write_px(input logic [2:0] a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clock);
      wr_en = 1'b0;
   endtask

   task automatic run_frame(input logic [2:0][23:0] exp, input bit poke,
                            input bit sc_wr, input logic [23:0] sc_data);
      int n;
      for (int k = 0; k < 3; k++) q.push_back(exp[k]);
      en_pulses = 0;
      start = 1'b1;
      if (sc_wr) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = sc_data; end
      @(negedge clock);
      start = 1'b0; wr_en = 1'b0;
      start_cyc = cyc;
      check("busy_on_start", busy, 1);
      if (poke) begin
         repeat (1500) @(negedge clock);
         start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'h123456;
         @(negedge clock);
         start = 1'b0; wr_en = 1'b0;
      end
      n = 0;
      while (!done && n < 8000) begin @(negedge clock); n++; end
      check("done_seen", done, 1);
      check("done_after_last_fall", cyc - last_fall, 101);
      check("busy_at_done", busy, 0);
      check("enable_pulses", en_pulses, 3);
      check("scoreboard_drained", q.size(), 0);
      @(negedge clock);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
   endtask

   initial begin
      #(20 * 95000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, rise_c, err_c;
      wr_en = 0; start = 0; wr_addr = 0; wr_data = 0;
      t_wr_en = 0; t_start = 0; t_wr_addr = 0; t_wr_data = 0; t_bit_ready = 0;
      en_pulses = 0; start_cyc = 0; last_fall = 0;

      // writes applied in order [0],[1],[2]; exp[k] is pixel k of the frame
      vecs[0].addr = {3'd2, 3'd1, 3'd0};
      vecs[0].data = {24'h0000FF, 24'hFF0000, 24'h80C0E0};
      vecs[0].exp  = {24'h0000FF, 24'hFF0000, 24'h80C0E0};
      vecs[1].addr = {3'd7, 3'd1, 3'd5};
      vecs[1].data = {24'h111111, 24'h00FF00, 24'hABCDEF};
      vecs[1].exp  = {24'h0000FF, 24'h00FF00, 24'h80C0E0};
      vecs[2].addr = {3'd3, 3'd2, 3'd2};
      vecs[2].data = {24'h999999, 24'hDDEEFF, 24'h0A0B0C};
      vecs[2].exp  = {24'hDDEEFF, 24'h00FF00, 24'h80C0E0};

      repeat (3) @(negedge clock);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_error", error, 0);
      check("reset_enable", enable, 0);
      check("reset_rgb", {r, g, b}, 0);
      check("reset_to_busy", t_busy, 0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 3; k++) write_px(vecs[i].addr[k], vecs[i].data[k]);
         run_frame(vecs[i].exp, 1'b0, 1'b0, 24'h0);
      end

      // mid-frame start and write while busy, then the following frame
      run_frame(vecs[2].exp, 1'b1, 1'b0, 24'h0);
      run_frame(vecs[2].exp, 1'b0, 1'b0, 24'h0);

      // start and write in the same idle cycle: write lands before the read
      run_frame({vecs[2].exp[2], vecs[2].exp[1], 24'h5A5A5A}, 1'b0, 1'b1, 24'h5A5A5A);

      // asynchronous reset during WAIT_LO of pixel 1
      write_px(3'd0, 24'h010203);
      write_px(3'd1, 24'h040506);
      write_px(3'd2, 24'h070809);
      for (int k = 0; k < 3; k++) q.push_back(24'h010203 + 24'h030303 * k);
      en_pulses = 0;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      start_cyc = cyc;
      n = 0;
      while (en_pulses < 2 && n < 4000) begin @(negedge clock); n++; end
      check("reached_pixel1", en_pulses, 2);
      repeat (100) @(negedge clock);
      #3 reset_n = 1'b0;
      #1;
      check("rst_enable", enable, 0);
      check("rst_busy", busy, 0);
      check("rst_rgb", {r, g, b}, 0);
      check("rst_done", done, 0);
      q.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      write_px(3'd0, 24'hA1B2C3);
      write_px(3'd1, 24'h0F0E0D);
      write_px(3'd2, 24'h102030);
      run_frame({24'h102030, 24'h0F0E0D, 24'hA1B2C3}, 1'b0, 1'b0, 24'h0);

      // handshake timeout: encoder never answers
      t_start = 1'b1;
      @(negedge clock);
      t_start = 1'b0;
      check("to_busy_on_start", t_busy, 1);
      n = 0;
      while (!t_enable && n < 20) begin @(negedge clock); n++; end
      check("to_enable_rise", t_enable, 1);
      rise_c = cyc;
      n = 0;
      while (!t_error && n < 200) begin @(negedge clock); n++; end
      err_c = cyc;
      check("to_error_set", t_error, 1);
      check("to_cycles", err_c - rise_c, 64);
      check("to_enable_low", t_enable, 0);
      check("to_busy_in_latch", t_busy, 1);
      n = 0;
      while (!t_done && n < 300) begin @(negedge clock); n++; end
      check("to_done_seen", t_done, 1);
      check("to_done_gap", cyc - err_c, 100);
      check("to_error_sticky", t_error, 1);
      check("to_busy_at_done", t_busy, 0);
      @(negedge clock);
      t_start = 1'b1;
      @(negedge clock);
      t_start = 1'b0;
      check("to_error_cleared", t_error, 0);
      check("to_busy_restart", t_busy, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
